dram_cmd_sequencer: RTL and testbench
=====================================

# dram_cmd_sequencer

Per-request DRAM command sequencer between the L2 request port and the DRAM command bus. It splits each request address into bank, row and column fields and keeps a per-bank open-row table (open-page policy). It issues PRE/ACT/RD/WR commands with programmable tRP/tRCD/tCL spacing and inserts periodic refresh. One request is in flight at a time.

## Interface
Parameters:
- ADDR_WIDTH, 13: request address width.
- NUM_OF_BANKS, 8: number of banks.
- NUM_OF_ROWS, 128: rows per bank.
- NUM_OF_COLS, 8: columns per row.
- T_RP, 3: PRE to ACT spacing, in cycles, ≥1.
- T_RCD, 3: ACT to RD/WR spacing, in cycles, ≥1.
- T_CL, 3: RD/WR to done spacing, in cycles, ≥1.
- T_RFC, 8: REF to next command spacing, in cycles, ≥1.
- T_REFI, 512: refresh interval, in cycles. Must exceed T_RP+T_RFC+T_RP+T_RCD+T_CL+4.

Ports (clock and reset first):
- clk, input, 1: single clock. All state changes on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- l2_req_valid, input, 1: a request is presented.
- l2_req_ready, output, 1: the block accepts a request this cycle.
- l2_req_address, input, ADDR_WIDTH: request address.
- l2_req_we, input, 1: 1 = write, 0 = read.
- l2_req_done, output, 1: one-cycle pulse when the accepted request completes.
- cmd, output, 3: command code. NOP=0, ACT=1, PRE=2, RD=3, WR=4, REF=5, PREA=6.
- cmd_bank, output, clog2(NUM_OF_BANKS): bank of the command.
- cmd_row, output, clog2(NUM_OF_ROWS): row of the command. Meaningful only on ACT.
- cmd_col, output, clog2(NUM_OF_COLS): column of the command. Meaningful only on RD/WR.

## Operation
- Address map: bank = addr[12:10], row = addr[9:3], col = addr[2:0].
- Handshake: l2_req_ready = 1 only in IDLE with no pending refresh. Transfer happens on valid && ready. Address and we are latched on transfer.
- Open-row table: one open bit and one row register per bank. Cleared at reset and after every refresh.
- Decision on transfer, against the latched bank:
  - Bank open, same row (hit): go to ACCESS.
  - Bank closed: go to ACTIVATE.
  - Bank open, different row (miss): go to PRECHARGE.
- States and commands:
  - IDLE: drives NOP.
  - PRECHARGE: issues PRE. Clears the bank's open bit. Next state WAIT_RP.
  - WAIT_RP: lasts T_RP-1 cycles, then ACTIVATE.
  - ACTIVATE: issues ACT. Sets the open bit and row register. Next state WAIT_RCD.
  - WAIT_RCD: lasts T_RCD-1 cycles, then ACCESS.
  - ACCESS: issues RD or WR. Next state WAIT_CL.
  - WAIT_CL: lasts T_CL-1 cycles, then DONE.
  - DONE: l2_req_done = 1. Next state IDLE.
  - A wait state with length 0 is skipped.
- cmd is non-NOP only in the one-cycle command states PRECHARGE, ACTIVATE, ACCESS, REF_PREA and REF_CMD.
- cmd_bank/cmd_row/cmd_col are 0 whenever cmd = NOP.
- One down-counter, width clog2(max timing parameter)+1, is shared by all wait states. It is reloaded on entry to each wait state.
- Reset, including mid-operation: return to IDLE. The open-row table, counters and pending refresh are all cleared. All outputs are 0 except l2_req_ready, which is 1 from the first cycle after reset release.

## Timing
Cycle 0 is the handshake cycle.
- Hit: RD/WR at cycle 1; done at cycle 1+T_CL.
- Closed bank: ACT at cycle 1; RD/WR at 1+T_RCD; done at 1+T_RCD+T_CL.
- Miss: PRE at cycle 1; ACT at 1+T_RP; RD/WR at 1+T_RP+T_RCD; done at 1+T_RP+T_RCD+T_CL.
- l2_req_ready returns to 1 in the cycle after done. Back-to-back throughput for hits is one request per T_CL+2 cycles.
- Outputs are combinational from the state register only. There is no input-to-output combinational path, except l2_req_ready, which also depends on the refresh-pending flag.

## Configuration
- Macro: DRAM_REFRESH_EN.
- Defined:
  - The refresh counter counts up from 0 and wraps at T_REFI-1. On the wrap it sets refresh_pending, which immediately forces l2_req_ready to 0.
  - Refresh starts from IDLE. An in-flight request always finishes first.
  - Refresh sequence: REF_PREA issues PREA only if any bank is open, followed by T_RP-1 wait cycles. Then REF_CMD issues REF with cmd_bank=0. Then REF_WAIT lasts T_RFC-1 cycles.
  - At the end of the sequence, the table is cleared, pending is cleared, and the state returns to IDLE.
  - Refresh has priority over a request presented in the same cycle as the wrap.
- Not defined: no refresh counter, no refresh states. REF and PREA are never issued.

## Structure
- Shared package dram_pkg holds:
  - the command code constants,
  - the state enumeration,
  - the address field bit positions.
- The address split uses the existing dram_address_translator sub-module, instantiated on the latched address.
- The sequencer is one always_ff block for state, counters and the table, plus one combinational output decode.

## Test plan
- Reset, then hold rst_n low for 3 cycles: cmd=NOP, l2_req_done=0, l2_req_ready=1 after release.
- Read 0x0408 on a closed bank: ACT bank1 row1 at cycle 1, RD col0 at cycle 4, done at cycle 7.
- Write 0x040D after that read (hit): WR bank1 col5 at cycle 1, done at cycle 4, no ACT.
- Read 0x0410 (miss, bank1 row2): PRE bank1 at cycle 1, ACT row2 at cycle 4, RD at cycle 7, done at cycle 10.
- With DRAM_REFRESH_EN and T_REFI=64, keep l2_req_valid high: ready drops at the wrap. PREA, then REF 3 cycles later, then ready returns after T_RFC. The next request to 0x0408 issues ACT (table cleared).
- Assert rst_n low during WAIT_RCD: next cycle state=IDLE, cmd=NOP, no done. A re-issued 0x0408 issues ACT again.

Source files
------------

// File: rtl/dram_pkg.sv
// Shared definitions for the DRAM command sequencer: command codes, sequencer
// states, address field positions and a small constant helper.
package dram_pkg;

    localparam logic [2:0] CMD_NOP  = 3'd0;
    localparam logic [2:0] CMD_ACT  = 3'd1;
    localparam logic [2:0] CMD_PRE  = 3'd2;
    localparam logic [2:0] CMD_RD   = 3'd3;
    localparam logic [2:0] CMD_WR   = 3'd4;
    localparam logic [2:0] CMD_REF  = 3'd5;
    localparam logic [2:0] CMD_PREA = 3'd6;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PRECHARGE,
        ST_WAIT_RP,
        ST_ACTIVATE,
        ST_WAIT_RCD,
        ST_ACCESS,
        ST_WAIT_CL,
        ST_DONE,
        ST_REF_PREA,
        ST_REF_WAIT_RP,
        ST_REF_CMD,
        ST_REF_WAIT
    } state_e;

    // Address layout: bank = addr[12:10], row = addr[9:3], col = addr[2:0]
    localparam int COL_LSB  = 0;
    localparam int ROW_LSB  = 3;
    localparam int BANK_LSB = 10;

    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/dram_address_translator.sv
// Splits a request address into bank, row and column fields.
module dram_address_translator
    import dram_pkg::*;
#(
    parameter int ADDR_WIDTH = 13,
    parameter int BANK_W     = 3,
    parameter int ROW_W      = 7,
    parameter int COL_W      = 3
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic [BANK_W-1:0]     bank_o,
    output logic [ROW_W-1:0]      row_o,
    output logic [COL_W-1:0]      col_o
);

    assign bank_o = addr_i[BANK_LSB +: BANK_W];
    assign row_o  = addr_i[ROW_LSB  +: ROW_W];
    assign col_o  = addr_i[COL_LSB  +: COL_W];

endmodule

// File: rtl/dram_cmd_sequencer.sv
// Open-page DRAM command sequencer: one request in flight, PRE/ACT/RD/WR with
// programmable spacing. Periodic refresh is built only when DRAM_REFRESH_EN is defined.
module dram_cmd_sequencer
    import dram_pkg::*;
#(
    parameter int ADDR_WIDTH   = 13,
    parameter int NUM_OF_BANKS = 8,
    parameter int NUM_OF_ROWS  = 128,
    parameter int NUM_OF_COLS  = 8,
    parameter int T_RP         = 3,
    parameter int T_RCD        = 3,
    parameter int T_CL         = 3,
    parameter int T_RFC        = 8,
    parameter int T_REFI       = 512
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            l2_req_valid,
    output logic                            l2_req_ready,
    input  logic [ADDR_WIDTH-1:0]           l2_req_address,
    input  logic                            l2_req_we,
    output logic                            l2_req_done,
    output logic [2:0]                      cmd,
    output logic [$clog2(NUM_OF_BANKS)-1:0] cmd_bank,
    output logic [$clog2(NUM_OF_ROWS)-1:0]  cmd_row,
    output logic [$clog2(NUM_OF_COLS)-1:0]  cmd_col
);

    localparam int BANK_W = $clog2(NUM_OF_BANKS);
    localparam int ROW_W  = $clog2(NUM_OF_ROWS);
    localparam int COL_W  = $clog2(NUM_OF_COLS);
    localparam int MAX_T  = max_of4(T_RP, T_RCD, T_CL, T_RFC);
    localparam int CNT_W  = $clog2(MAX_T) + 1;

    state_e                             state_q;
    logic [ADDR_WIDTH-1:0]              addr_q;
    logic                               we_q;
    logic [NUM_OF_BANKS-1:0]            open_q;
    logic [NUM_OF_BANKS-1:0][ROW_W-1:0] row_tbl_q;
    logic [CNT_W-1:0]                   cnt_q;
    logic                               refresh_due;

    logic [BANK_W-1:0] bank_q;
    logic [ROW_W-1:0]  row_q;
    logic [COL_W-1:0]  col_q;
    logic [BANK_W-1:0] req_bank;
    logic [ROW_W-1:0]  req_row;
    logic [COL_W-1:0]  unused_req_col;

    dram_address_translator #(
        .ADDR_WIDTH(ADDR_WIDTH), .BANK_W(BANK_W), .ROW_W(ROW_W), .COL_W(COL_W)
    ) u_xlat_latched (
        .addr_i (addr_q),
        .bank_o (bank_q),
        .row_o  (row_q),
        .col_o  (col_q)
    );

    // The hit/miss decision is taken in the handshake cycle, before addr_q holds the request.
    dram_address_translator #(
        .ADDR_WIDTH(ADDR_WIDTH), .BANK_W(BANK_W), .ROW_W(ROW_W), .COL_W(COL_W)
    ) u_xlat_req (
        .addr_i (l2_req_address),
        .bank_o (req_bank),
        .row_o  (req_row),
        .col_o  (unused_req_col)
    );

`ifdef DRAM_REFRESH_EN
    localparam int REFI_W = $clog2(T_REFI);
    logic [REFI_W-1:0] refi_cnt_q;
    logic              ref_pend_q;
    logic              refi_wrap;

    assign refi_wrap   = (refi_cnt_q == REFI_W'(T_REFI - 1));
    assign refresh_due = ref_pend_q | refi_wrap;
`else
    logic unused_refresh_cfg;
    assign unused_refresh_cfg = (T_REFI > 0);
    assign refresh_due        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            we_q      <= 1'b0;
            open_q    <= '0;
            row_tbl_q <= '0;
            cnt_q     <= '0;
`ifdef DRAM_REFRESH_EN
            refi_cnt_q <= '0;
            ref_pend_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (refresh_due) begin
                        state_q <= ST_REF_PREA;
                    end else if (l2_req_valid) begin
                        addr_q <= l2_req_address;
                        we_q   <= l2_req_we;
                        if (open_q[req_bank] && (row_tbl_q[req_bank] == req_row))
                            state_q <= ST_ACCESS;
                        else if (open_q[req_bank])
                            state_q <= ST_PRECHARGE;
                        else
                            state_q <= ST_ACTIVATE;
                    end
                end
                ST_PRECHARGE: begin
                    open_q[bank_q] <= 1'b0;
                    if (T_RP > 1) begin
                        state_q <= ST_WAIT_RP;
                        cnt_q   <= CNT_W'(T_RP - 1);
                    end else begin
                        state_q <= ST_ACTIVATE;
                    end
                end
                ST_WAIT_RP: begin
                    if (cnt_q == CNT_W'(1)) state_q <= ST_ACTIVATE;
                    else                    cnt_q   <= cnt_q - 1'b1;
                end
                ST_ACTIVATE: begin
                    open_q[bank_q]    <= 1'b1;
                    row_tbl_q[bank_q] <= row_q;
                    if (T_RCD > 1) begin
                        state_q <= ST_WAIT_RCD;
                        cnt_q   <= CNT_W'(T_RCD - 1);
                    end else begin
                        state_q <= ST_ACCESS;
                    end
                end
                ST_WAIT_RCD: begin
                    if (cnt_q == CNT_W'(1)) state_q <= ST_ACCESS;
                    else                    cnt_q   <= cnt_q - 1'b1;
                end
                ST_ACCESS: begin
                    if (T_CL > 1) begin
                        state_q <= ST_WAIT_CL;
                        cnt_q   <= CNT_W'(T_CL - 1);
                    end else begin
                        state_q <= ST_DONE;
                    end
                end
                ST_WAIT_CL: begin
                    if (cnt_q == CNT_W'(1)) state_q <= ST_DONE;
                    else                    cnt_q   <= cnt_q - 1'b1;
                end
                ST_DONE: state_q <= ST_IDLE;
`ifdef DRAM_REFRESH_EN
                ST_REF_PREA: begin
                    if (T_RP > 1) begin
                        state_q <= ST_REF_WAIT_RP;
                        cnt_q   <= CNT_W'(T_RP - 1);
                    end else begin
                        state_q <= ST_REF_CMD;
                    end
                end
                ST_REF_WAIT_RP: begin
                    if (cnt_q == CNT_W'(1)) state_q <= ST_REF_CMD;
                    else                    cnt_q   <= cnt_q - 1'b1;
                end
                ST_REF_CMD: begin
                    if (T_RFC > 1) begin
                        state_q <= ST_REF_WAIT;
                        cnt_q   <= CNT_W'(T_RFC - 1);
                    end else begin
                        state_q    <= ST_IDLE;
                        open_q     <= '0;
                        row_tbl_q  <= '0;
                        ref_pend_q <= 1'b0;
                    end
                end
                ST_REF_WAIT: begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_q    <= ST_IDLE;
                        open_q     <= '0;
                        row_tbl_q  <= '0;
                        ref_pend_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
`ifdef DRAM_REFRESH_EN
            // Placed after the case so a wrap is never lost to a same-cycle clear.
            refi_cnt_q <= refi_wrap ? '0 : refi_cnt_q + 1'b1;
            if (refi_wrap) ref_pend_q <= 1'b1;
`endif
        end
    end

    always_comb begin
        cmd          = CMD_NOP;
        cmd_bank     = '0;
        cmd_row      = '0;
        cmd_col      = '0;
        l2_req_done  = 1'b0;
        l2_req_ready = (state_q == ST_IDLE) && !refresh_due;
        case (state_q)
            ST_PRECHARGE: begin
                cmd      = CMD_PRE;
                cmd_bank = bank_q;
            end
            ST_ACTIVATE: begin
                cmd      = CMD_ACT;
                cmd_bank = bank_q;
                cmd_row  = row_q;
            end
            ST_ACCESS: begin
                cmd      = we_q ? CMD_WR : CMD_RD;
                cmd_bank = bank_q;
                cmd_col  = col_q;
            end
            ST_DONE: l2_req_done = 1'b1;
`ifdef DRAM_REFRESH_EN
            ST_REF_PREA: begin
                if (|open_q) cmd = CMD_PREA;
            end
            ST_REF_CMD: cmd = CMD_REF;
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dram_cmd_sequencer.sv
// Directed bench for dram_cmd_sequencer; refresh checks are active when DRAM_REFRESH_EN is defined.
module tb_dram_cmd_sequencer;
    import dram_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        l2_req_valid = 1'b0;
    logic        l2_req_we = 1'b0;
    logic [12:0] l2_req_address = '0;
    logic        l2_req_ready;
    logic        l2_req_done;
    logic [2:0]  cmd;
    logic [2:0]  cmd_bank;
    logic [6:0]  cmd_row;
    logic [2:0]  cmd_col;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    dram_cmd_sequencer #(.T_REFI(64)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .l2_req_valid   (l2_req_valid),
        .l2_req_ready   (l2_req_ready),
        .l2_req_address (l2_req_address),
        .l2_req_we      (l2_req_we),
        .l2_req_done    (l2_req_done),
        .cmd            (cmd),
        .cmd_bank       (cmd_bank),
        .cmd_row        (cmd_row),
        .cmd_col        (cmd_col)
    );

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [2:0] ec, input logic [2:0] eb,
                       input logic [6:0] er, input logic [2:0] ecol,
                       input logic ed, input logic erdy);
        total++;
        assert (cmd === ec) else begin
            bad++; $error("FAIL %s cyc=%0d cmd got=%0d exp=%0d", tag, cyc, cmd, ec);
        end
        total++;
        assert (cmd_bank === eb) else begin
            bad++; $error("FAIL %s cyc=%0d bank got=%0d exp=%0d", tag, cyc, cmd_bank, eb);
        end
        if (ec == CMD_ACT) begin
            total++;
            assert (cmd_row === er) else begin
                bad++; $error("FAIL %s cyc=%0d row got=%0d exp=%0d", tag, cyc, cmd_row, er);
            end
        end
        if (ec == CMD_RD || ec == CMD_WR) begin
            total++;
            assert (cmd_col === ecol) else begin
                bad++; $error("FAIL %s cyc=%0d col got=%0d exp=%0d", tag, cyc, cmd_col, ecol);
            end
        end
        total++;
        assert (l2_req_done === ed) else begin
            bad++; $error("FAIL %s cyc=%0d done got=%0b exp=%0b", tag, cyc, l2_req_done, ed);
        end
        total++;
        assert (l2_req_ready === erdy) else begin
            bad++; $error("FAIL %s cyc=%0d ready got=%0b exp=%0b", tag, cyc, l2_req_ready, erdy);
        end
    endtask

    task automatic stepchk(input string tag, input logic [2:0] ec, input logic [2:0] eb,
                           input logic [6:0] er, input logic [2:0] ecol,
                           input logic ed, input logic erdy);
        step();
        chk(tag, ec, eb, er, ecol, ed, erdy);
    endtask

    task automatic nops(input string tag, input int n);
        for (int i = 0; i < n; i++) stepchk(tag, CMD_NOP, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic drive(input logic [12:0] a, input logic we);
        l2_req_valid   = 1'b1;
        l2_req_address = a;
        l2_req_we      = we;
    endtask

    initial begin
        // Reset held for 3 cycles
        repeat (3) @(posedge clk);
        #1;
        total++;
        assert (cmd === CMD_NOP) else begin
            bad++; $error("FAIL rst_cmd got=%0d exp=%0d", cmd, CMD_NOP);
        end
        total++;
        assert (l2_req_done === 1'b0) else begin
            bad++; $error("FAIL rst_done got=%0b exp=0", l2_req_done);
        end
        rst_n = 1'b1;
        cyc   = 0;
        chk("idle0", CMD_NOP, 0, 0, 0, 1'b0, 1'b1);

        // Closed-bank read 0x0408: bank1 row1 col0
        drive(13'h0408, 1'b0);
        step(); l2_req_valid = 1'b0;
        chk("A_act", CMD_ACT, 1, 1, 0, 1'b0, 1'b0);
        nops("A_rcd", 2);
        stepchk("A_rd", CMD_RD, 1, 0, 0, 1'b0, 1'b0);
        nops("A_cl", 2);
        stepchk("A_done", CMD_NOP, 0, 0, 0, 1'b1, 1'b0);
        stepchk("A_idle", CMD_NOP, 0, 0, 0, 1'b0, 1'b1);

        // Hit write 0x040D: bank1 col5
        drive(13'h040D, 1'b1);
        step(); l2_req_valid = 1'b0;
        chk("B_wr", CMD_WR, 1, 0, 5, 1'b0, 1'b0);
        nops("B_cl", 2);
        stepchk("B_done", CMD_NOP, 0, 0, 0, 1'b1, 1'b0);
        stepchk("B_idle", CMD_NOP, 0, 0, 0, 1'b0, 1'b1);

        // Miss read 0x0410: bank1 row2 col0
        drive(13'h0410, 1'b0);
        step(); l2_req_valid = 1'b0;
        chk("C_pre", CMD_PRE, 1, 0, 0, 1'b0, 1'b0);
        nops("C_rp", 2);
        stepchk("C_act", CMD_ACT, 1, 2, 0, 1'b0, 1'b0);
        nops("C_rcd", 2);
        stepchk("C_rd", CMD_RD, 1, 0, 0, 1'b0, 1'b0);
        nops("C_cl", 2);
        stepchk("C_done", CMD_NOP, 0, 0, 0, 1'b1, 1'b0);
        stepchk("C_idle", CMD_NOP, 0, 0, 0, 1'b0, 1'b1);

        while (cyc < 62) step();
        chk("pre_wrap", CMD_NOP, 0, 0, 0, 1'b0, 1'b1);
        step();
        drive(13'h0408, 1'b0);
`ifdef DRAM_REFRESH_EN
        // Cycle 63 is the refresh wrap: request held off, PREA/REF sequence follows
        chk("wrap", CMD_NOP, 0, 0, 0, 1'b0, 1'b0);
        stepchk("R_prea", CMD_PREA, 0, 0, 0, 1'b0, 1'b0);
        nops("R_rp", 2);
        stepchk("R_ref", CMD_REF, 0, 0, 0, 1'b0, 1'b0);
        nops("R_rfc", 7);
        stepchk("R_ready", CMD_NOP, 0, 0, 0, 1'b0, 1'b1);
        step(); l2_req_valid = 1'b0;
        chk("R_act", CMD_ACT, 1, 1, 0, 1'b0, 1'b0);
        nops("R_rcd", 2);
        stepchk("R_rd", CMD_RD, 1, 0, 0, 1'b0, 1'b0);
        nops("R_cl", 2);
        stepchk("R_done", CMD_NOP, 0, 0, 0, 1'b1, 1'b0);
        stepchk("R_idle", CMD_NOP, 0, 0, 0, 1'b0, 1'b1);
`else
        // No refresh: 0x0408 misses against open row 2 of bank 1
        chk("norf_rdy", CMD_NOP, 0, 0, 0, 1'b0, 1'b1);
        step(); l2_req_valid = 1'b0;
        chk("N_pre", CMD_PRE, 1, 0, 0, 1'b0, 1'b0);
        nops("N_rp", 2);
        stepchk("N_act", CMD_ACT, 1, 1, 0, 1'b0, 1'b0);
        nops("N_rcd", 2);
        stepchk("N_rd", CMD_RD, 1, 0, 0, 1'b0, 1'b0);
        nops("N_cl", 2);
        stepchk("N_done", CMD_NOP, 0, 0, 0, 1'b1, 1'b0);
        stepchk("N_idle", CMD_NOP, 0, 0, 0, 1'b0, 1'b1);
`endif

        // Reset asserted during WAIT_RCD of a write to 0x0808 (bank2 row1)
        drive(13'h0808, 1'b1);
        step(); l2_req_valid = 1'b0;
        chk("M_act", CMD_ACT, 2, 1, 0, 1'b0, 1'b0);
        stepchk("M_rcd", CMD_NOP, 0, 0, 0, 1'b0, 1'b0);
        rst_n = 1'b0;
        step();
        total++;
        assert (cmd === CMD_NOP) else begin
            bad++; $error("FAIL M_rst_cmd got=%0d exp=%0d", cmd, CMD_NOP);
        end
        total++;
        assert (l2_req_done === 1'b0) else begin
            bad++; $error("FAIL M_rst_done got=%0b exp=0", l2_req_done);
        end
        step();
        rst_n = 1'b1;
        cyc   = 0;
        chk("M_idle", CMD_NOP, 0, 0, 0, 1'b0, 1'b1);

        // Table cleared by reset: 0x0408 activates again
        drive(13'h0408, 1'b0);
        step(); l2_req_valid = 1'b0;
        chk("D_act", CMD_ACT, 1, 1, 0, 1'b0, 1'b0);
        nops("D_rcd", 2);
        stepchk("D_rd", CMD_RD, 1, 0, 0, 1'b0, 1'b0);
        nops("D_cl", 2);
        stepchk("D_done", CMD_NOP, 0, 0, 0, 1'b1, 1'b0);
        stepchk("D_idle", CMD_NOP, 0, 0, 0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
